// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, stage control record and stage-count helper for the pipelined adder.
package adder_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SLICE_DEF = 4;
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctrl_t;
  function automatic int num_stages(input int w, input int s);
    return (w / s < 1) ? 1 : w / s;
  endfunction
endpackage

// File: rtl/pipelined_rc_adder_rca_slice.sv
// rca_slice: combinational N-bit ripple-carry adder built from a full-adder chain.
module rca_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic c;
  always_comb begin
    c = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/pipelined_rc_adder.sv
// pipelined_rc_adder: add/subtract pipeline rippling one SLICE-bit chunk per stage with a global-stall stream handshake.
module pipelined_rc_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = num_stages(WIDTH, SLICE);
  // Data vectors scale with WIDTH, so only the fixed-size control bits live in the shared struct.
  stage_ctrl_t      ctl   [STAGES];
  logic [WIDTH-1:0] rem_a [STAGES];
  logic [WIDTH-1:0] rem_b [STAGES];
  logic [WIDTH-1:0] part  [STAGES];
  logic [WIDTH-1:0] b_in;
  logic advance, ovf_q, zero_q;
  assign advance = !ctl[STAGES-1].valid || out_ready;
  assign in_ready = advance;
  assign b_in = sub ? ~b : b;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] pa, pb, ps, ns;
    stage_ctrl_t pc;
    logic [SLICE-1:0] s;
    logic co;
    if (k == 0) begin : g_head
      assign pa = a;
      assign pb = b_in;
      assign ps = '0;
      assign pc = '{valid: in_valid, sub: sub, carry: sub ^ cin, a_msb: a[WIDTH-1], b_msb: b_in[WIDTH-1]};
    end else begin : g_body
      assign pa = rem_a[k-1];
      assign pb = rem_b[k-1];
      assign ps = part[k-1];
      assign pc = ctl[k-1];
    end
    rca_slice #(.N(SLICE)) u_slice (.a(pa[SLICE-1:0]), .b(pb[SLICE-1:0]), .cin(pc.carry), .sum(s), .cout(co));
    // New slice enters at the top so slice 0 reaches the bottom after the last stage.
    if (WIDTH > SLICE) begin : g_shift
      assign ns = {s, ps[WIDTH-1:SLICE]};
    end else begin : g_flat
      assign ns = s;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        ctl[k] <= '0;
        rem_a[k] <= '0;
        rem_b[k] <= '0;
        part[k] <= '0;
      end else if (advance) begin
        ctl[k] <= '{valid: pc.valid, sub: pc.sub, carry: co, a_msb: pc.a_msb, b_msb: pc.b_msb};
        rem_a[k] <= pa >> SLICE;
        rem_b[k] <= pb >> SLICE;
        part[k] <= ns;
      end
    end
    if (k == STAGES - 1) begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (pc.a_msb == pc.b_msb) && (s[SLICE-1] != pc.a_msb);
          zero_q <= ~|ns;
        end
      end
    end
  end
  assign out_valid = ctl[STAGES-1].valid;
  assign cout = ctl[STAGES-1].carry;
  assign sum = part[STAGES-1];
  assign ovf = ovf_q;
  assign zero = zero_q;
endmodule
